rd_ptr_empty_ctrl: RTL and testbench

Read-side pointer controller for the async FIFO. It generalises the read counter and empty generator with:
- a built-in write-pointer synchroniser of configurable depth;
- a wrap-bit pointer sized from the address width;
- an occupancy level with a programmable almost-empty flag;
- an underflow flag.

It sits in the read clock domain between the FIFO RAM read port and the write-side pointer controller.

---
 rtl/fifo_pkg.sv | 24 ++
 rtl/ptr_sync.sv | 30 +++
 rtl/rd_ptr_empty_ctrl.sv | 80 ++++++++
 tb/tb_rd_ptr_empty_ctrl.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared async-FIFO helpers: Gray/binary conversion and synchroniser limits.
package fifo_pkg;

  localparam int SYNC_STAGES_MIN = 2;

  // Conversions run on a wide vector so any pointer up to 32 bits can use them;
  // callers zero-extend their pointer in and size-cast the result back.
  localparam int PTR_W_MAX = 32;
  typedef logic [PTR_W_MAX-1:0] gray_vec_t;

  function automatic gray_vec_t bin2gray(input gray_vec_t bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic gray_vec_t gray2bin(input gray_vec_t gray);
    gray_vec_t bin;
    bin = gray;
    for (int i = 1; i < PTR_W_MAX; i++) begin
      bin = bin ^ (gray >> i);
    end
    return bin;
  endfunction

endpackage

// File: rtl/ptr_sync.sv
// Reset-to-zero flop chain that carries a Gray pointer into another clock domain.
module ptr_sync
  import fifo_pkg::*;
#(
  parameter int WIDTH  = 5,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  localparam int N = (STAGES < SYNC_STAGES_MIN) ? SYNC_STAGES_MIN : STAGES;

  logic [N-1:0][WIDTH-1:0] chain;

  // NOTE: every synchroniser stage is reset; leaving them unreset would let X
  // propagate into empty/level after power-up until the chain flushes.
  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= '0;
    end else begin
      chain <= {chain[N-2:0], d};
    end
  end

  assign q = chain[N-1];

endmodule

// File: rtl/rd_ptr_empty_ctrl.sv
// Read-domain pointer controller: synchronised write pointer, empty and
// almost-empty flags, occupancy level and underflow pulse.
module rd_ptr_empty_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_W      = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              rd_en,
  input  logic [ADDR_W:0]   wr_ptr_gray,
  input  logic [ADDR_W:0]   ae_level,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [ADDR_W:0]   rd_ptr_gray,
  output logic              empty,
  output logic              almost_empty,
  output logic [ADDR_W:0]   rd_level,
  output logic              underflow
);

  localparam int PTR_W = ADDR_W + 1;

  logic [PTR_W-1:0] wq;
  logic [PTR_W-1:0] wq_bin;
  logic [PTR_W-1:0] rd_bin;
  logic [PTR_W-1:0] rd_bin_next;
  logic [PTR_W-1:0] rd_gray_next;
  logic [PTR_W-1:0] level_next;
  logic             rd_fire;
  logic             empty_next;
  logic             almost_empty_next;

  ptr_sync #(
    .WIDTH  (PTR_W),
    .STAGES (SYNC_STAGES)
  ) u_wr_sync (
    .clk (clk),
    .rst (rst),
    .d   (wr_ptr_gray),
    .q   (wq)
  );

  // NOTE: every output of this block is assigned on every pass with no
  // conditional branches, so no latch can be inferred.
  always_comb begin
    rd_fire           = rd_en & ~empty;
    rd_bin_next       = rd_bin + PTR_W'(rd_fire);
    rd_gray_next      = PTR_W'(bin2gray(gray_vec_t'(rd_bin_next)));
    wq_bin            = PTR_W'(gray2bin(gray_vec_t'(wq)));
    // Flags track wq every cycle so empty drops on its own once writes show up.
    empty_next        = (rd_gray_next == wq);
    level_next        = wq_bin - rd_bin_next;
    almost_empty_next = (level_next <= ae_level);
  end

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      rd_bin       <= '0;
      rd_ptr_gray  <= '0;
      empty        <= 1'b1;
      almost_empty <= 1'b1;
      rd_level     <= '0;
      underflow    <= 1'b0;
    end else begin
      rd_bin       <= rd_bin_next;
      rd_ptr_gray  <= rd_gray_next;
      empty        <= empty_next;
      almost_empty <= almost_empty_next;
      rd_level     <= level_next;
      underflow    <= rd_en & empty;
    end
  end

  assign rd_addr = rd_bin[ADDR_W-1:0];

endmodule

// File: tb/tb_rd_ptr_empty_ctrl.sv
// Directed scoreboard bench for rd_ptr_empty_ctrl (ADDR_W=4, SYNC_STAGES=2).
module tb_rd_ptr_empty_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       clr;
  logic       rd_en;
  logic [4:0] wr_ptr_gray;
  logic [4:0] ae_level;
  logic [3:0] rd_addr;
  logic [4:0] rd_ptr_gray;
  logic       empty;
  logic       almost_empty;
  logic [4:0] rd_level;
  logic       underflow;

  rd_ptr_empty_ctrl #(
    .ADDR_W      (4),
    .SYNC_STAGES (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .clr          (clr),
    .rd_en        (rd_en),
    .wr_ptr_gray  (wr_ptr_gray),
    .ae_level     (ae_level),
    .rd_addr      (rd_addr),
    .rd_ptr_gray  (rd_ptr_gray),
    .empty        (empty),
    .almost_empty (almost_empty),
    .rd_level     (rd_level),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    string tag;
    int    bin;
    bit    emp;
    bit    ae;
    int    lvl;
    bit    uf;
  } exp_t;

  exp_t sb_q[$];
  int   tests = 0;
  int   fails = 0;
  int   wb    = 0;
  int   eb    = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input int bin, input bit emp,
                            input bit ae, input int lvl, input bit uf);
    exp_t e;
    e.tag = tag; e.bin = bin & 31; e.emp = emp; e.ae = ae; e.lvl = lvl; e.uf = uf;
    sb_q.push_back(e);
  endtask

  // Advance one edge, then compare every expectation queued for that edge.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check({e.tag, ".rd_addr"},      32'(rd_addr),      32'(e.bin & 15));
      check({e.tag, ".rd_ptr_gray"},  32'(rd_ptr_gray),  32'((e.bin ^ (e.bin >> 1)) & 31));
      check({e.tag, ".empty"},        32'(empty),        32'(e.emp));
      check({e.tag, ".almost_empty"}, 32'(almost_empty), 32'(e.ae));
      check({e.tag, ".rd_level"},     32'(rd_level),     32'(e.lvl));
      check({e.tag, ".underflow"},    32'(underflow),    32'(e.uf));
    end
  endtask

  task automatic drive_wr(input int b);
    wr_ptr_gray = 5'((b ^ (b >> 1)) & 31);
  endtask

  task automatic do_reset(input logic [4:0] wg);
    rst = 1'b1; clr = 1'b0; rd_en = 1'b0; wr_ptr_gray = wg;
    repeat (2) begin
      expect_out("reset", 0, 1, 1, 0, 0);
      tick();
    end
    rst = 1'b0;
    eb  = 0;
  endtask

  initial begin
    ae_level = 5'd0;

    // Reset with a non-zero write pointer already present.
    do_reset(5'b00011);
    expect_out("rst_rel1", 0, 1, 1, 0, 0); tick();
    expect_out("rst_rel2", 0, 1, 1, 0, 0); tick();
    expect_out("rst_sync", 0, 0, 0, 2, 0); tick();

    // Single entry, last-entry read, then underflow for three cycles.
    do_reset(5'b00000);
    wb = 1; drive_wr(wb);
    expect_out("se_j",   0, 1, 1, 0, 0); tick();
    expect_out("se_j1",  0, 1, 1, 0, 0); tick();
    expect_out("se_vis", 0, 0, 0, 1, 0); tick();
    rd_en = 1'b1; eb = 1;
    expect_out("se_read", eb, 1, 1, 0, 0); tick();
    repeat (3) begin
      expect_out("uf", eb, 1, 1, 0, 1); tick();
    end
    rd_en = 1'b0;
    expect_out("uf_end", eb, 1, 1, 0, 0); tick();

    // Full fill and drain with almost-empty threshold 3.
    ae_level = 5'd3;
    do_reset(5'b00000);
    wb = 16; drive_wr(wb);
    expect_out("fill_j",   0, 1, 1, 0, 0); tick();
    expect_out("fill_j1",  0, 1, 1, 0, 0); tick();
    expect_out("fill_vis", 0, 0, 0, 16, 0); tick();
    rd_en = 1'b1;
    for (int n = 1; n <= 16; n++) begin
      eb = n;
      expect_out("drain", n, n == 16, (16 - n) <= 3, 16 - n, 0);
      tick();
    end
    rd_en = 1'b0;
    expect_out("drained", eb, 1, 1, 0, 0); tick();

    // 40 write/read pairs across the 31->0 pointer wrap.
    for (int i = 0; i < 40; i++) begin
      wb = (wb + 1) % 32; drive_wr(wb);
      expect_out("wrap_j",   eb, 1, 1, 0, 0); tick();
      expect_out("wrap_j1",  eb, 1, 1, 0, 0); tick();
      expect_out("wrap_vis", eb, 0, 1, 1, 0); tick();
      rd_en = 1'b1; eb = (eb + 1) % 32;
      expect_out("wrap_rd",  eb, 1, 1, 0, 0); tick();
      rd_en = 1'b0;
    end

    // Read coinciding with a newly visible write keeps the level constant.
    wb = (wb + 1) % 32; drive_wr(wb);
    expect_out("sim_pre_j",   eb, 1, 1, 0, 0); tick();
    expect_out("sim_pre_j1",  eb, 1, 1, 0, 0); tick();
    expect_out("sim_pre_vis", eb, 0, 1, 1, 0); tick();
    wb = (wb + 1) % 32; drive_wr(wb);
    expect_out("sim_j",  eb, 0, 1, 1, 0); tick();
    expect_out("sim_j1", eb, 0, 1, 1, 0); tick();
    rd_en = 1'b1; eb = (eb + 1) % 32;
    expect_out("sim_both", eb, 0, 1, 1, 0); tick();
    rd_en = 1'b0;
    expect_out("sim_after", eb, 0, 1, 1, 0); tick();

    // Build level 7, then clear mid-read with the write side cleared too.
    wb = (wb + 6) % 32; drive_wr(wb);
    expect_out("l7_j",   eb, 0, 1, 1, 0); tick();
    expect_out("l7_j1",  eb, 0, 1, 1, 0); tick();
    expect_out("l7_vis", eb, 0, 0, 7, 0); tick();
    clr = 1'b1; rd_en = 1'b1; wb = 0; drive_wr(wb);
    expect_out("clr", 0, 1, 1, 0, 0); tick();
    clr = 1'b0; rd_en = 1'b0; eb = 0;
    tick();
    expect_out("post_clr", 0, 1, 1, 0, 0); tick();
    wb = 1; drive_wr(wb);
    expect_out("resume_j",   0, 1, 1, 0, 0); tick();
    expect_out("resume_j1",  0, 1, 1, 0, 0); tick();
    expect_out("resume_vis", 0, 0, 1, 1, 0); tick();
    rd_en = 1'b1; eb = 1;
    expect_out("resume_rd", eb, 1, 1, 0, 0); tick();
    rd_en = 1'b0;
    expect_out("resume_idle", eb, 1, 1, 0, 0); tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
